// File: rtl/odd_cnt_pkg.sv
// Shared types, constants and sequence-step helper for the odd up/down counter
// and its on-line response checker.
package odd_cnt_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int               CNT_W   = 3;
  localparam logic [CNT_W-1:0] ODD_MIN = 3'd1;
  localparam logic [CNT_W-1:0] ODD_MAX = 3'd7;
  localparam logic [CNT_W-1:0] STEP    = 3'd2;

  // Returns {next_value, next_dir}; endpoints bounce before the +/-2 step,
  // so the 3-bit arithmetic can never wrap.
  function automatic logic [CNT_W:0] next_odd(input logic [CNT_W-1:0] value,
                                              input logic             dir_up);
    logic [CNT_W:0] res;
    if (value == ODD_MAX) begin
      res = {ODD_MAX - STEP, 1'b0};
    end else if (value == ODD_MIN) begin
      res = {ODD_MIN + STEP, 1'b1};
    end else if (dir_up) begin
      res = {value + STEP, 1'b1};
    end else begin
      res = {value - STEP, 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/odd_counter_checker_predictor.sv
// Combinational one-step predictor of the bouncing odd sequence.
module odd_seq_predictor
  import odd_cnt_pkg::*;
(
  input  logic [CNT_W-1:0] value,
  input  logic             dir_up,
  output logic [CNT_W-1:0] next_value,
  output logic             next_dir
);

  assign {next_value, next_dir} = next_odd(value, dir_up);

endmodule

// File: rtl/odd_counter_checker.sv
// On-line checker for the odd up/down counter: locks onto 1,3,5,7,5,3,...,
// pulses err on each deviation and keeps a saturating error count.
module odd_counter_checker
  import odd_cnt_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             p1,
  input  logic             p2,
  input  logic             p3,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] expected,
  output logic             dir_up
);

  localparam logic [ERR_W-1:0] CNT_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ONE  = ERR_W'(1);
  localparam logic [2:0]       LOSS_LIM = 3'(LOSS_THRESH);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] prev_r, prev_s;
  logic [2:0]       miss_r, miss_s;
  logic             err_r, err_s;
  logic [ERR_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] exp_r, exp_s;
  logic             dir_r, dir_s;

  logic [CNT_W-1:0] cur_s, ref_s, pred_val_s, nxt_val_s;
  logic             pred_dir_s, nxt_dir_s, match_s, step2_s;

  assign cur_s   = {p3, p2, p1};
  assign match_s = (cur_s == exp_r);
  assign ref_s   = (state_r == LOCKED) ? exp_r : prev_r;
  assign step2_s = ({1'b0, cur_s} == {1'b0, prev_r} + 4'd2) ||
                   ({1'b0, prev_r} == {1'b0, cur_s} + 4'd2);

  // Predictor operand select: an even miss coasts on the old prediction,
  // everything else resynchronises on the observed sample.
  always_comb begin
    pred_val_s = cur_s;
    pred_dir_s = (cur_s > ref_s);
    if ((state_r == LOCKED) && match_s) begin
      pred_dir_s = dir_r;
    end else if ((state_r == LOCKED) && !cur_s[0]) begin
      pred_val_s = exp_r;
      pred_dir_s = dir_r;
    end else begin
      pred_dir_s = (cur_s > ref_s);
    end
  end

  odd_seq_predictor u_pred (
    .value      (pred_val_s),
    .dir_up     (pred_dir_s),
    .next_value (nxt_val_s),
    .next_dir   (nxt_dir_s)
  );

  // Next-state, miss/error bookkeeping and prediction update.
  always_comb begin
    state_s = state_r;
    prev_s  = prev_r;
    miss_s  = miss_r;
    err_s   = 1'b0;
    cnt_s   = cnt_r;
    exp_s   = exp_r;
    dir_s   = dir_r;
    if (en) begin
      case (state_r)
        HUNT: begin
          if (cur_s[0]) begin
            prev_s  = cur_s;
            state_s = ACQUIRE;
          end else begin
            state_s = HUNT;
          end
        end
        ACQUIRE: begin
          if (cur_s[0] && step2_s) begin
            state_s = LOCKED;
            exp_s   = nxt_val_s;
            dir_s   = nxt_dir_s;
          end else if (cur_s[0]) begin
            prev_s  = cur_s;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          if (match_s) begin
            miss_s = 3'd0;
            exp_s  = nxt_val_s;
            dir_s  = nxt_dir_s;
          end else begin
            err_s = 1'b1;
            if (cnt_r != CNT_MAX) begin
              cnt_s = cnt_r + CNT_ONE;
            end else begin
              cnt_s = cnt_r;
            end
            if ((miss_r + 3'd1) >= LOSS_LIM) begin
              state_s = HUNT;
              miss_s  = 3'd0;
              prev_s  = 3'd0;
              exp_s   = 3'd0;
              dir_s   = 1'b0;
            end else begin
              miss_s = miss_r + 3'd1;
              exp_s  = nxt_val_s;
              dir_s  = nxt_dir_s;
            end
          end
        end
        default: begin
          state_s = HUNT;
          miss_s  = 3'd0;
          prev_s  = 3'd0;
          exp_s   = 3'd0;
          dir_s   = 1'b0;
        end
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
      prev_r  <= 3'd0;
      miss_r  <= 3'd0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
      exp_r   <= 3'd0;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      prev_r  <= prev_s;
      miss_r  <= miss_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
      exp_r   <= exp_s;
      dir_r   <= dir_s;
    end
  end

  assign locked    = (state_r == LOCKED);
  assign err       = err_r;
  assign err_count = cnt_r;
  assign expected  = exp_r;
  assign dir_up    = dir_r;

endmodule

// File: tb/tb_odd_counter_checker.sv
// Directed bench for odd_counter_checker; a second instance with a 2-bit
// error counter covers saturation.
module tb_odd_counter_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       p1  = 1'b0;
  logic       p2  = 1'b0;
  logic       p3  = 1'b0;

  logic       locked, err, dir_up;
  logic [7:0] err_count;
  logic [2:0] expected;

  logic       s_locked, s_err, s_dir_up;
  logic [1:0] s_err_count;
  logic [2:0] s_expected;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  odd_counter_checker #(.ERR_W(8), .LOSS_THRESH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .p1(p1), .p2(p2), .p3(p3),
    .locked(locked), .err(err), .err_count(err_count),
    .expected(expected), .dir_up(dir_up)
  );

  odd_counter_checker #(.ERR_W(2), .LOSS_THRESH(3)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .p1(p1), .p2(p2), .p3(p3),
    .locked(s_locked), .err(s_err), .err_count(s_err_count),
    .expected(s_expected), .dir_up(s_dir_up)
  );

  task automatic step(input logic [2:0] v);
    @(negedge clk);
    {p3, p2, p1} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int exp_v);
    vectors++;
    assert (observed === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input int lk, input int e,
                           input int cnt, input int ex, input int d);
    check({tag, ".locked"},    int'(locked),    lk);
    check({tag, ".err"},       int'(err),       e);
    check({tag, ".err_count"}, int'(err_count), cnt);
    check({tag, ".expected"},  int'(expected),  ex);
    check({tag, ".dir_up"},    int'(dir_up),    d);
  endtask

  initial begin
    // reset for two cycles
    rst = 1'b1;
    step(3'd0);
    step(3'd0);
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // clean lock on 1,3,5,7,5,3,1,3
    step(3'd1); check_all("clean1", 0, 0, 0, 0, 0);
    step(3'd3); check_all("clean3", 1, 0, 0, 5, 1);
    step(3'd5); check_all("clean5", 1, 0, 0, 7, 1);
    step(3'd7); check_all("clean7", 1, 0, 0, 5, 0);
    step(3'd5); check_all("clean5d", 1, 0, 0, 3, 0);
    step(3'd3); check_all("clean3d", 1, 0, 0, 1, 0);
    step(3'd1); check_all("clean1b", 1, 0, 0, 3, 1);
    step(3'd3); check_all("clean3b", 1, 0, 0, 5, 1);

    // single glitch while expecting 5 going up
    step(3'd4); check_all("glitch4", 1, 1, 1, 7, 1);
    step(3'd7); check_all("glitch7", 1, 0, 1, 5, 0);
    step(3'd5); check_all("glitch5", 1, 0, 1, 3, 0);

    // loss of lock after three consecutive misses, then relock on 5,3
    step(3'd2); check_all("loss1", 1, 1, 2, 1, 0);
    step(3'd2); check_all("loss2", 1, 1, 3, 3, 1);
    step(3'd2); check_all("loss3", 0, 1, 4, 0, 0);
    step(3'd5); check_all("relock5", 0, 0, 4, 0, 0);
    step(3'd3); check_all("relock3", 1, 0, 4, 1, 0);

    // endpoint locks
    rst = 1'b1; step(3'd0); check_all("rst_ep1", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(3'd5); step(3'd7); check_all("ep57", 1, 0, 0, 5, 0);
    rst = 1'b1; step(3'd0); rst = 1'b0;
    step(3'd3); step(3'd1); check_all("ep31", 1, 0, 0, 3, 1);

    // reset in the middle of LOCKED (rst wins over the matching sample)
    rst = 1'b1; step(3'd3); check_all("rst_mid", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // enable freeze with a broken sequence, then resume correctly
    step(3'd1); step(3'd3); check_all("en_lock", 1, 0, 0, 5, 1);
    en = 1'b0;
    step(3'd6); check_all("en0_a", 1, 0, 0, 5, 1);
    step(3'd0); check_all("en0_b", 1, 0, 0, 5, 1);
    step(3'd2); check_all("en0_c", 1, 0, 0, 5, 1);
    step(3'd4); check_all("en0_d", 1, 0, 0, 5, 1);
    step(3'd1); check_all("en0_e", 1, 0, 0, 5, 1);
    en = 1'b1;
    step(3'd5); check_all("en_resume", 1, 0, 0, 7, 1);

    // saturation: ten mismatches with relock in between
    rst = 1'b1; step(3'd0); rst = 1'b0;
    check("sat.reset", int'(s_err_count), 0);
    for (int i = 0; i < 3; i++) begin
      step(3'd1); step(3'd3);
      step(3'd2); step(3'd2); step(3'd2);
    end
    check("sat.after9", int'(s_err_count), 3);
    check("main.after9", int'(err_count), 9);
    step(3'd1); step(3'd3); step(3'd2);
    check("sat.err_pulse", int'(s_err), 1);
    check("sat.err_count", int'(s_err_count), 3);
    check("main.err_count", int'(err_count), 10);
    check("sat.locked", int'(s_locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
